// File: rtl/vram_arb_rr_if.sv
// Bus bundle for vram_arb_rr: video-gen read port, NUM_CH packed client channels, the
// single-port VRAM side and the shared read-data return.
//   slave  : arbiter view (takes requests and VRAM read data, drives acks and VRAM strobes)
//   master : client + memory view (the opposite directions)
// Optional macro VRAM_ARB_PERF_EN adds perf_clr_i / perf_wait_o.
interface vram_arb_rr_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();

  logic                       vgen_sel_i;
  logic [ADDR_W-1:0]          vgen_addr_i;
  logic [NUM_CH-1:0]          ch_sel_i;
  logic [NUM_CH-1:0]          ch_wr_i;
  logic [4*NUM_CH-1:0]        ch_wr_mask_i;
  logic [ADDR_W*NUM_CH-1:0]   ch_addr_i;
  logic [DATA_W*NUM_CH-1:0]   ch_data_i;
  logic [NUM_CH-1:0]          ch_ack_o;
  logic                       vram_sel_o;
  logic                       vram_wr_o;
  logic [3:0]                 vram_wr_mask_o;
  logic [ADDR_W-1:0]          vram_addr_o;
  logic [DATA_W-1:0]          vram_wdata_o;
  logic [DATA_W-1:0]          vram_rdata_i;
  logic [DATA_W-1:0]          rdata_o;
`ifdef VRAM_ARB_PERF_EN
  logic                       perf_clr_i;
  logic [16*NUM_CH-1:0]       perf_wait_o;
`endif

  modport slave (
`ifdef VRAM_ARB_PERF_EN
    input  perf_clr_i,
    output perf_wait_o,
`endif
    input  vgen_sel_i, vgen_addr_i, ch_sel_i, ch_wr_i, ch_wr_mask_i, ch_addr_i, ch_data_i,
    input  vram_rdata_i,
    output ch_ack_o, vram_sel_o, vram_wr_o, vram_wr_mask_o, vram_addr_o, vram_wdata_o,
    output rdata_o
  );

  modport master (
`ifdef VRAM_ARB_PERF_EN
    output perf_clr_i,
    input  perf_wait_o,
`endif
    output vgen_sel_i, vgen_addr_i, ch_sel_i, ch_wr_i, ch_wr_mask_i, ch_addr_i, ch_data_i,
    output vram_rdata_i,
    input  ch_ack_o, vram_sel_o, vram_wr_o, vram_wr_mask_o, vram_addr_o, vram_wdata_o,
    input  rdata_o
  );

endinterface

// File: rtl/vram_arb_rr.sv
// VRAM arbiter: the video-gen read port has absolute priority; NUM_CH read/write client
// channels share the remaining slots round-robin. Grant is combinational, the per-channel
// ack is registered one cycle after the grant (read data from the 1-cycle VRAM lines up
// with that ack).
// Ports:
//   clk      : system clock
//   reset_i  : synchronous active-high reset; blocks all VRAM access while high
//   bus      : vram_arb_rr_if.slave (requests, acks, VRAM strobes, read data)
// Optional macro VRAM_ARB_PERF_EN: per-channel 16-bit saturating wait-cycle counters
// (bus.perf_wait_o), cleared by reset_i or bus.perf_clr_i.
module vram_arb_rr #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic            clk,
  input  logic            reset_i,
  vram_arb_rr_if.slave    bus
);

  localparam int unsigned PtrW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_CH - 1);

  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] eligible;
  logic [PtrW-1:0]   cand;
  logic [PtrW-1:0]   grant_idx;
  logic              grant_vld;

  logic              wr_g;
  logic [3:0]        mask_g;
  logic [ADDR_W-1:0] addr_g;
  logic [DATA_W-1:0] data_g;

  // A channel being acked this cycle still holds its request; masking it avoids a second
  // service of the same request.
  always_comb begin
    eligible  = bus.ch_sel_i & ~ack_q;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!reset_i && !bus.vgen_sel_i) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cand = PtrW'((32'(rr_ptr_q) + i) % NUM_CH);
        if (!grant_vld && eligible[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Channel fields of the selected index (channel 0 when nothing is granted, keeping the
  // don't-care outputs stable).
  always_comb begin
    wr_g   = 1'b0;
    mask_g = '0;
    addr_g = '0;
    data_g = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_idx == PtrW'(i)) begin
        wr_g   = bus.ch_wr_i[i];
        mask_g = bus.ch_wr_mask_i[4*i +: 4];
        addr_g = bus.ch_addr_i[ADDR_W*i +: ADDR_W];
        data_g = bus.ch_data_i[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    bus.vram_sel_o     = 1'b0;
    bus.vram_wr_o      = 1'b0;
    bus.vram_wr_mask_o = mask_g;
    bus.vram_addr_o    = addr_g;
    bus.vram_wdata_o   = data_g;
    if (reset_i) begin
      bus.vram_sel_o = 1'b0;
    end else if (bus.vgen_sel_i) begin
      bus.vram_sel_o  = 1'b1;
      bus.vram_addr_o = bus.vgen_addr_i;
    end else if (grant_vld) begin
      bus.vram_sel_o = 1'b1;
      bus.vram_wr_o  = wr_g;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ack_d[i] = grant_vld && (grant_idx == PtrW'(i));
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ack_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      ack_q    <= ack_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.ch_ack_o = ack_q;
  assign bus.rdata_o  = bus.vram_rdata_i;

`ifdef VRAM_ARB_PERF_EN
  logic [NUM_CH-1:0][15:0] perf_q;

  // Counts every requesting cycle without a grant, including the ack cycle of a held request.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (reset_i || bus.perf_clr_i) begin
        perf_q[i] <= '0;
      end else if (bus.ch_sel_i[i] && !ack_d[i] && (perf_q[i] != 16'hFFFF)) begin
        perf_q[i] <= perf_q[i] + 16'd1;
      end
    end
  end

  assign bus.perf_wait_o = perf_q;
`endif

endmodule

// File: tb/tb_vram_arb_rr.sv
module tb_vram_arb_rr;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned G      = DATA_W / 4;
  localparam int          Words  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vram_arb_rr_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arb_rr #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] apply_mask(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [3:0] mk);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int j = 0; j < 4; j++) if (mk[j]) r[j*G +: G] = new_v[j*G +: G];
    return r;
  endfunction

  // Memory the DUT drives, plus an independent expected copy.
  logic [DATA_W-1:0] mem     [Words];
  logic [DATA_W-1:0] ref_mem [Words];

  always @(posedge clk) begin
    if (bus.vram_sel_o) begin
      if (bus.vram_wr_o)
        mem[bus.vram_addr_o] <= apply_mask(mem[bus.vram_addr_o], bus.vram_wdata_o,
                                           bus.vram_wr_mask_o);
      else
        bus.vram_rdata_i <= mem[bus.vram_addr_o];
    end
  end

  // Reference model state
  int                m_ptr = 0;
  logic [NUM_CH-1:0] m_ack = '0;
  logic              m_rd_valid = 1'b0;
  logic [DATA_W-1:0] m_rd_exp = '0;
  int                n_access = 0;
  int                m_perf [NUM_CH];

  // Called at posedge+1 with inputs set; checks this cycle's access and the next ack.
  task automatic step();
    logic [NUM_CH-1:0] sel, ack_exp;
    int g, c;
    logic w;
    logic [3:0] mk;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    #3;
    sel = bus.ch_sel_i;
    g = -1;
    if (!reset && !bus.vgen_sel_i) begin
      for (int off = 0; off < NUM_CH; off++) begin
        c = (m_ptr + off) % NUM_CH;
        if (g < 0 && sel[c] && !m_ack[c]) g = c;
      end
    end
    w = 1'b0; mk = '0; a = '0; d = '0;
    if (g >= 0) begin
      w  = bus.ch_wr_i[g];
      mk = bus.ch_wr_mask_i[4*g +: 4];
      a  = bus.ch_addr_i[ADDR_W*g +: ADDR_W];
      d  = bus.ch_data_i[DATA_W*g +: DATA_W];
    end
    if (reset) begin
      check("rst_sel", 64'(bus.vram_sel_o), 64'(0));
      check("rst_wr", 64'(bus.vram_wr_o), 64'(0));
    end else if (bus.vgen_sel_i) begin
      check("vgen_sel", 64'(bus.vram_sel_o), 64'(1));
      check("vgen_wr", 64'(bus.vram_wr_o), 64'(0));
      check("vgen_addr", 64'(bus.vram_addr_o), 64'(bus.vgen_addr_i));
    end else if (g >= 0) begin
      check("ch_sel", 64'(bus.vram_sel_o), 64'(1));
      check("ch_wr", 64'(bus.vram_wr_o), 64'(w));
      check("ch_addr", 64'(bus.vram_addr_o), 64'(a));
      if (w) begin
        check("ch_wdata", 64'(bus.vram_wdata_o), 64'(d));
        check("ch_mask", 64'(bus.vram_wr_mask_o), 64'(mk));
      end
    end else begin
      check("idle_sel", 64'(bus.vram_sel_o), 64'(0));
      check("idle_wr", 64'(bus.vram_wr_o), 64'(0));
    end
    if (bus.vram_sel_o) n_access++;
    ack_exp = '0;
    m_rd_valid = 1'b0;
    if (reset) begin
      m_ptr = 0;
    end else if (g >= 0) begin
      ack_exp[g] = 1'b1;
      m_ptr = (g + 1) % NUM_CH;
      if (w) ref_mem[a] = apply_mask(ref_mem[a], d, mk);
      else begin
        m_rd_valid = 1'b1;
        m_rd_exp   = ref_mem[a];
      end
    end
    m_ack = ack_exp;
`ifdef VRAM_ARB_PERF_EN
    for (int k = 0; k < NUM_CH; k++) begin
      if (reset || bus.perf_clr_i) m_perf[k] = 0;
      else if (sel[k] && g != k && m_perf[k] < 65535) m_perf[k]++;
    end
`endif
    @(posedge clk);
    #1;
    check("ack", 64'(bus.ch_ack_o), 64'(m_ack));
    if (m_rd_valid) check("rdata", 64'(bus.rdata_o), 64'(m_rd_exp));
`ifdef VRAM_ARB_PERF_EN
    for (int k = 0; k < NUM_CH; k++)
      check("perf", 64'(bus.perf_wait_o[16*k +: 16]), 64'(m_perf[k]));
`endif
  endtask

  task automatic set_req(input int k, input logic s, input logic w, input logic [3:0] mk,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.ch_sel_i[k]                   = s;
    bus.ch_wr_i[k]                    = w;
    bus.ch_wr_mask_i[4*k +: 4]        = mk;
    bus.ch_addr_i[ADDR_W*k +: ADDR_W] = a;
    bus.ch_data_i[DATA_W*k +: DATA_W] = d;
  endtask

  task automatic rand_req(input int k);
    set_req(k, 1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)),
            ADDR_W'($urandom_range(31)), DATA_W'($urandom));
  endtask

  int rr_seq [6] = '{0, 1, 2, 0, 1, 2};
  int ack2_cnt;

  initial begin
    for (int i = 0; i < Words; i++) begin
      mem[i]     = DATA_W'(i * 40503 + 7);
      ref_mem[i] = DATA_W'(i * 40503 + 7);
    end
    for (int k = 0; k < NUM_CH; k++) m_perf[k] = 0;
    bus.vram_rdata_i = '0;
    bus.ch_sel_i = '0; bus.ch_wr_i = '0; bus.ch_wr_mask_i = '0;
    bus.ch_addr_i = '0; bus.ch_data_i = '0;
`ifdef VRAM_ARB_PERF_EN
    bus.perf_clr_i = 1'b0;
`endif

    // Reset with everything requesting, vgen included.
    reset = 1'b1;
    bus.vgen_sel_i = 1'b1; bus.vgen_addr_i = 16'h0100;
    for (int k = 0; k < NUM_CH; k++) set_req(k, 1'b1, 1'b0, 4'h0, ADDR_W'(k + 1), '0);
    step();
    step();
    check("rst_ack", 64'(bus.ch_ack_o), 64'(0));

    // Round-robin from ch0 with all channels reading continuously.
    reset = 1'b0;
    bus.vgen_sel_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_seq", 64'(bus.ch_ack_o), 64'(1) << rr_seq[i]);
    end
    bus.ch_sel_i = '0;
    step();

    // vgen stall while ch1 waits.
    set_req(1, 1'b1, 1'b0, 4'h0, 16'h0005, '0);
    bus.vgen_sel_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.vgen_addr_i = ADDR_W'($urandom);
      step();
      check("vgen_noack", 64'(bus.ch_ack_o), 64'(0));
    end
    bus.vgen_sel_i = 1'b0;
    step();
    check("vgen_after", 64'(bus.ch_ack_o), 64'(3'b010));
    bus.ch_sel_i = '0;
    step();

    // Masked write then read back.
    mem[16] = 16'h1234; ref_mem[16] = 16'h1234;
    set_req(0, 1'b1, 1'b1, 4'b0101, 16'h0010, 16'hABCD);
    step();
    check("wr_ack", 64'(bus.ch_ack_o), 64'(3'b001));
    set_req(0, 1'b0, 1'b0, 4'h0, 16'h0010, '0);
    step();
    set_req(0, 1'b1, 1'b0, 4'h0, 16'h0010, '0);
    step();
    check("rd_ack", 64'(bus.ch_ack_o), 64'(3'b001));
    check("wmask_rd", 64'(bus.rdata_o), 64'(16'h1B3D));
    bus.ch_sel_i = '0;
    step();

    // Single request held through its ack cycle.
    n_access = 0; ack2_cnt = 0;
    set_req(2, 1'b1, 1'b0, 4'h0, 16'h0003, '0);
    step(); ack2_cnt += int'(bus.ch_ack_o[2]);
    step(); ack2_cnt += int'(bus.ch_ack_o[2]);
    bus.ch_sel_i = '0;
    step(); ack2_cnt += int'(bus.ch_ack_o[2]);
    step(); ack2_cnt += int'(bus.ch_ack_o[2]);
    check("single_ack", 64'(ack2_cnt), 64'(1));
    check("single_access", 64'(n_access), 64'(1));

`ifdef VRAM_ARB_PERF_EN
    bus.perf_clr_i = 1'b1;
    step();
    bus.perf_clr_i = 1'b0;
    bus.vgen_sel_i = 1'b1;
    set_req(1, 1'b1, 1'b0, 4'h0, 16'h0007, '0);
    for (int i = 0; i < 10; i++) step();
    check("perf_10", 64'(bus.perf_wait_o[16 +: 16]), 64'(10));
    bus.perf_clr_i = 1'b1;
    step();
    check("perf_clr", 64'(bus.perf_wait_o[16 +: 16]), 64'(0));
    bus.perf_clr_i = 1'b0;
    for (int i = 0; i < 70000; i++) step();
    check("perf_sat", 64'(bus.perf_wait_o[16 +: 16]), 64'(16'hFFFF));
    bus.vgen_sel_i = 1'b0;
    step();
    step();
    bus.ch_sel_i = '0;
    step();
`endif

    // Random traffic: clients hold requests until acked, vgen and reset strike at random.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.ch_ack_o[k]) begin
          if ($urandom_range(1) == 1) rand_req(k);
          else bus.ch_sel_i[k] = 1'b0;
        end else if (!bus.ch_sel_i[k] && $urandom_range(9) < 3) begin
          rand_req(k);
        end
      end
      bus.vgen_sel_i  = ($urandom_range(4) == 0);
      bus.vgen_addr_i = ADDR_W'($urandom);
      reset           = ($urandom_range(99) == 0);
`ifdef VRAM_ARB_PERF_EN
      bus.perf_clr_i  = ($urandom_range(49) == 0);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
